board_access_arbiter: RTL
=========================

// Module: board_access_arbiter
// PURPOSE
//  Owns the Connect-4 board store (ROWS x COLS cells, CELL_W bits each) and shares it
//  between the pixel renderer (reads) and the game FSM (writes / new-game clear).
//  Renderer reads are served every cycle. Game writes go into a small FIFO and are
//  committed only while in_display=0 (blanking), so the picture never tears mid-frame.
//  Sits between hvsync_generator (inDisplayArea -> in_display), the renderer and game logic.
// PARAMETERS
//  ROWS       6  board rows; row index 0..ROWS-1
//  COLS       7  board columns; col index 0..COLS-1
//  CELL_W     2  bits per cell (0=empty, 1=player1, 2=player2, 3=reserved)
//  FIFO_DEPTH 4  write-queue entries, power of 2
// PORTS
//  clk         in   1        system clock, same clock as hvsync_generator
//  rst_n       in   1        asynchronous, active-low reset
//  in_display  in   1        high while the beam is in the visible area
//  rd_en       in   1        renderer read strobe
//  rd_row      in   3        renderer row
//  rd_col      in   3        renderer column
//  rd_data     out  CELL_W   registered read data
//  rd_valid    out  1        rd_data valid (rd_en delayed 1 cycle)
//  wr_valid    in   1        game write request
//  wr_ready    out  1        = !fifo_full && !clr_busy; transfer when wr_valid&&wr_ready
//  wr_row      in   3        write row
//  wr_col      in   3        write column
//  wr_data     in   CELL_W   write value
//  clr_req     in   1        one-cycle pulse: clear whole board (new game)
//  clr_busy    out  1        clear pending or in progress
//  fifo_level  out  3        queued writes, 0..FIFO_DEPTH
//  err_oob     out  1        one-cycle pulse: accepted write had row>=ROWS or col>=COLS
// BEHAVIOUR
//  Reset (rst_n=0, async): all cells 0, FIFO empty, state IDLE, clr_pending=0, rd_data=0,
//   rd_valid=0, err_oob=0, fifo_level=0, clr_busy=0. wr_ready reads 1 during and after reset.
//   rst_n low mid-DRAIN or mid-CLEAR aborts the operation; the board is still all-zero.
//  Cell index = row*COLS + col (6-bit).
//  Read: rd_data/rd_valid registered, 1-cycle latency, in any state, in_display ignored.
//   Out-of-range read returns 0. Read and commit to the same cell in the same cycle
//   returns the old value (read-before-write).
//  Enqueue: a handshake pushes {row,col,data}. An out-of-range write is consumed and
//   not queued; err_oob pulses the next cycle. Full FIFO: wr_ready=0, nothing is lost.
//  Clear: clr_req sets clr_pending and flushes the FIFO the same cycle. A write
//   handshaking in that cycle is discarded. clr_req while clr_busy=1 is ignored.
//   clr_busy = clr_pending | (state==CLEAR).
//  FSM (decisions on registered state and the current in_display):
//   IDLE : in_display=0 & clr_pending -> CLEAR (idx=0, clr_pending=0);
//          else in_display=0 & !empty -> DRAIN; else stay.
//   DRAIN: each cycle with in_display=0, pop one entry and write its cell.
//          -> IDLE when the FIFO becomes empty, or in_display=1 (no write that cycle),
//          or clr_pending (clear wins).
//   CLEAR: each cycle with in_display=0, write cell[idx]=0, idx++.
//          in_display=1 holds idx (pause, no write). After idx=ROWS*COLS-1 -> IDLE.
//  Commit order is FIFO order. Simultaneous push and pop: level unchanged.
//   Push into a full FIFO is impossible because wr_ready=0.
//  Pointers wrap modulo FIFO_DEPTH. fifo_level counts 0..FIFO_DEPTH inclusive.
// TESTING
//  T1 reset: hold rst_n=0 3 cycles, then read all 42 cells -> every rd_data=0,
//     rd_valid 1 cycle after each rd_en.
//  T2 deferred write: in_display=1, write (5,3)=1 -> fifo_level=1, cell still 0;
//     drop in_display -> cell (5,3)=1 within 2 cycles, fifo_level=0.
//  T3 backpressure: in_display=1, issue 5 writes -> wr_ready=0 after the 4th,
//     fifo_level=4; blanking -> 4 commits in order over 4 cycles, 5th then accepted.
//  T4 out-of-range: write row=6 or col=7 -> err_oob pulse, fifo_level unchanged,
//     board unchanged.
//  T5 clear: fill cells, queue 2 writes, pulse clr_req -> FIFO flushed; clear pauses
//     while in_display=1 and finishes after 42 blanking cycles; then clr_busy=0,
//     all cells 0.
//  T6 collision: same-cycle read and commit of (0,0) 2->1 -> rd_data=2, next read 1;
//     rst_n low mid-CLEAR -> outputs at reset values immediately.

Source files
------------

// File: rtl/board_access_arbiter.sv
// -----------------------------------------------------------------------------
// board_access_arbiter
// Owns the Connect-4 board store and shares it between the pixel renderer
// (reads, served every cycle) and the game FSM (queued writes and new-game
// clear). Queued writes and the clear sweep only touch the board while
// in_display=0, so the picture never changes mid-frame.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   in_display          high while the beam is in the visible area
//   rd_en/rd_row/rd_col renderer read request
//   rd_data, rd_valid   registered read result, 1-cycle latency
//   wr_valid/wr_ready   game write handshake, payload wr_row/wr_col/wr_data
//   clr_req             one-cycle new-game pulse
//   clr_busy            clear pending or sweeping
//   fifo_level          number of queued writes, 0..FIFO_DEPTH
//   err_oob             pulse: an accepted write was outside the board
// -----------------------------------------------------------------------------
module board_access_arbiter #(
    parameter int ROWS       = 6,
    parameter int COLS       = 7,
    parameter int CELL_W     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_display,
    input  logic              rd_en,
    input  logic [2:0]        rd_row,
    input  logic [2:0]        rd_col,
    output logic [CELL_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_row,
    input  logic [2:0]        wr_col,
    input  logic [CELL_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [2:0]        fifo_level,
    output logic              err_oob
);

    localparam int         CELLS    = ROWS * COLS;
    localparam int         PTR_W    = $clog2(FIFO_DEPTH);
    localparam int         ENT_W    = 6 + CELL_W;
    localparam logic [5:0] LAST_IDX = 6'(CELLS - 1);
    localparam logic [2:0] DEPTH_L  = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    function automatic logic in_range(input logic [2:0] row, input logic [2:0] col);
        return (row < 3'(ROWS)) && (col < 3'(COLS));
    endfunction

    function automatic logic [5:0] cell_index(input logic [2:0] row, input logic [2:0] col);
        logic [5:0] r6;
        r6 = {3'b000, row};
        return (r6 * 6'(COLS)) + {3'b000, col};
    endfunction

    logic [CELL_W-1:0] board_r [CELLS];
    logic [ENT_W-1:0]  fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [2:0]        level_r;
    logic [5:0]        clr_idx_r;
    logic              clr_pending_r;
    state_t            state_r, next_state_s;

    logic              empty_s, full_s, clr_accept_s, hs_s, wr_in_range_s;
    logic              push_s, pop_s, oob_s, clr_wr_s, clr_go_s;
    logic [ENT_W-1:0]  head_s;
    logic [5:0]        head_idx_s;

    assign empty_s       = (level_r == 3'd0);
    assign full_s        = (level_r == DEPTH_L);
    assign clr_busy      = clr_pending_r | (state_r == ST_CLEAR);
    assign wr_ready      = !full_s && !clr_busy;
    assign fifo_level    = level_r;
    assign clr_accept_s  = clr_req && !clr_busy;
    assign hs_s          = wr_valid && wr_ready;
    assign wr_in_range_s = in_range(wr_row, wr_col);
    // A write arriving in the same cycle as an accepted clear is dropped.
    assign push_s        = hs_s && wr_in_range_s && !clr_accept_s;
    assign oob_s         = hs_s && !wr_in_range_s && !clr_accept_s;
    assign head_s        = fifo_mem_r[rd_ptr_r];
    assign head_idx_s    = cell_index(head_s[ENT_W-1 -: 3], head_s[ENT_W-4 -: 3]);

    // Next-state and commit decisions from registered state and live in_display.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        clr_wr_s     = 1'b0;
        clr_go_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!in_display && clr_pending_r) begin
                    next_state_s = ST_CLEAR;
                    clr_go_s     = 1'b1;
                end else if (!in_display && !empty_s) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (clr_pending_r || in_display || empty_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    pop_s = 1'b1;
                    if ((level_r == 3'd1) && !push_s) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_DRAIN;
                    end
                end
            end
            ST_CLEAR: begin
                if (in_display) begin
                    next_state_s = ST_CLEAR;
                end else begin
                    clr_wr_s = 1'b1;
                    if (clr_idx_r == LAST_IDX) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_CLEAR;
                    end
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, clear sweep index and pending-clear flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            clr_idx_r     <= 6'd0;
            clr_pending_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (clr_go_s) begin
                clr_idx_r <= 6'd0;
            end else if (clr_wr_s) begin
                clr_idx_r <= clr_idx_r + 6'd1;
            end else begin
                clr_idx_r <= clr_idx_r;
            end
            if (clr_accept_s) begin
                clr_pending_r <= 1'b1;
            end else if (clr_go_s) begin
                clr_pending_r <= 1'b0;
            end else begin
                clr_pending_r <= clr_pending_r;
            end
        end
    end

    // Write queue: storage, wrapping pointers and occupancy; flushed by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {ENT_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= 3'd0;
        end else if (clr_accept_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {wr_row, wr_col, wr_data};
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 3'd1;
                2'b01:   level_r <= level_r - 3'd1;
                default: level_r <= level_r;
            endcase
        end
    end

    // Board store: one commit per cycle, clear sweep has priority over drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) begin
                board_r[i] <= {CELL_W{1'b0}};
            end
        end else if (clr_wr_s) begin
            board_r[clr_idx_r] <= {CELL_W{1'b0}};
        end else if (pop_s) begin
            board_r[head_idx_s] <= head_s[CELL_W-1:0];
        end
    end

    // Registered read port (samples old cell value on a same-cycle commit) and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= {CELL_W{1'b0}};
            rd_valid <= 1'b0;
            err_oob  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            err_oob  <= oob_s;
            if (rd_en) begin
                rd_data <= in_range(rd_row, rd_col) ? board_r[cell_index(rd_row, rd_col)]
                                                    : {CELL_W{1'b0}};
            end
        end
    end

endmodule
